// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file geometry for the writeback arbiter, register_file and benches.
package regfile_wb_arbiter_pkg;

    localparam int unsigned RF_DATA_W   = 20;
    localparam int unsigned RF_ADDR_W   = 4;
    localparam int unsigned RF_NUM_REGS = 16;

    typedef logic [RF_ADDR_W-1:0] rf_sel_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last granted index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Pick the first requester after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        grant   = '0;
        gnt_idx = ptr;
        cand    = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                gnt_idx     = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    // Pointer moves to the winner only when the grant is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PTR_W'(NUM_REQ - 1);
        end else if (advance) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback port arbiter for register_file with per-register busy scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned ADDR_W   = RF_ADDR_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         rf_write,
    output logic [ADDR_W-1:0]         rf_w_select,
    output logic                      rf_w,
    input  logic                      sb_set,
    input  logic [ADDR_W-1:0]         sb_addr,
    input  logic [ADDR_W-1:0]         rd1_sel,
    input  logic [ADDR_W-1:0]         rd2_sel,
    output logic                      rd_stall,
    output logic [NUM_REGS-1:0]       busy,
    output logic                      sb_err
);

    logic [NUM_REQ-1:0]  grant;
    logic                hs;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] busy_next;
    logic                err_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (hs),
        .grant   (grant)
    );

    assign req_ready = rst_n ? grant : '0;
    assign hs        = |req_ready;

    // Route the granted requester's select and data to the write stage.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Write stage: one registered write per handshake; select/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_w        <= 1'b0;
            rf_w_select <= '0;
            rf_write    <= '0;
        end else begin
            rf_w <= hs;
            if (hs) begin
                rf_w_select <= sel_addr;
                rf_write    <= sel_data;
            end
        end
    end

    // Retiring write clears, issue sets; set applied last so a new producer wins.
    always_comb begin
        busy_next = busy;
        if (rf_w) begin
            busy_next[rf_w_select] = 1'b0;
        end
        if (sb_set) begin
            busy_next[sb_addr] = 1'b1;
        end
        err_hit = sb_set && busy[sb_addr] && !(rf_w && (rf_w_select == sb_addr));
    end

    // Scoreboard state and sticky double-issue flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (err_hit) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign rd_stall = busy[rd1_sel] | busy[rd2_sel];

endmodule
